// File: rtl/mac3_seq_ctrl.sv
// mac3_seq_ctrl: sequencer for one 3-tap pipelined MAC.
// Issues operand groups, selects accumulate/restart, tracks in-flight outputs with
// a tag pipe, drains with zero bubbles and hands results to writeback (valid/ready).
// Optional feature: define MAC3_SEQ_CTRL_PERF_EN to add the perf_stall_cycles output.
module mac3_seq_ctrl #(
    parameter int CNT_WIDTH  = 8,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_num_groups,
    input  logic [CNT_WIDTH-1:0] cfg_num_outputs,
    input  logic                 operand_valid,
    output logic                 operand_ready,
    output logic                 mac_input_valid,
    output logic                 mac_accumulate,
    output logic                 mac_zero_operands,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CNT_WIDTH-1:0] result_index,
    output logic                 mac_out_written,
    output logic                 busy,
    output logic                 done
`ifdef MAC3_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   grp_cnt_reg, grp_cnt_next;
    logic [CNT_WIDTH-1:0]   out_cnt_reg, out_cnt_next;
    logic [CNT_WIDTH-1:0]   num_groups_reg, num_groups_next;
    logic [CNT_WIDTH-1:0]   num_outputs_reg, num_outputs_next;
    logic [PIPE_DEPTH-1:0]  tag_reg, tag_next;
    logic                   consumed_reg, consumed_next;
    logic [CNT_WIDTH-1:0]   idx_reg [PIPE_DEPTH];
    logic [CNT_WIDTH-1:0]   idx_src [PIPE_DEPTH];

    logic hold;
    logic issue;
    logic advance;
    logic last_grp;
    logic last_out;

    // A finished output sits at the last tag stage until writeback takes it once.
    assign result_valid    = tag_reg[PIPE_DEPTH-1] & ~consumed_reg;
    assign hold            = result_valid & ~result_ready;
    assign mac_out_written = result_valid & result_ready;
    assign result_index    = result_valid ? idx_reg[PIPE_DEPTH-1] : '0;
    assign busy            = (state_reg != IDLE);

    assign last_grp = (grp_cnt_reg == num_groups_reg - CNT_WIDTH'(1));
    assign last_out = (out_cnt_reg == num_outputs_reg - CNT_WIDTH'(1));
    assign issue    = (state_reg == RUN) & operand_valid & ~hold;
    // The MAC pipeline and its tag/index shadow move together, never during hold.
    assign advance  = issue | ((state_reg == DRAIN) & (|tag_reg) & ~hold);

    assign tag_next      = advance ? {tag_reg[PIPE_DEPTH-2:0], issue & last_grp} : tag_reg;
    assign consumed_next = advance ? 1'b0 : (mac_out_written ? 1'b1 : consumed_reg);

    // Index shadow: stage 0 captures the issuing output number, others shift.
    assign idx_src[0] = out_cnt_reg;
    generate
        for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_idx_src
            assign idx_src[gi] = idx_reg[gi-1];
        end
    endgenerate

    // Next-state, counter and output decode.
    always_comb begin
        state_next        = state_reg;
        grp_cnt_next      = grp_cnt_reg;
        out_cnt_next      = out_cnt_reg;
        num_groups_next   = num_groups_reg;
        num_outputs_next  = num_outputs_reg;
        operand_ready     = 1'b0;
        mac_input_valid   = 1'b0;
        mac_accumulate    = 1'b0;
        mac_zero_operands = 1'b0;
        done              = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    num_groups_next  = (cfg_num_groups == '0) ? CNT_WIDTH'(1) : cfg_num_groups;
                    num_outputs_next = cfg_num_outputs;
                    grp_cnt_next     = '0;
                    out_cnt_next     = '0;
                    state_next       = (cfg_num_outputs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                operand_ready   = issue;
                mac_input_valid = issue;
                mac_accumulate  = (grp_cnt_reg != '0);
                if (issue) begin
                    if (last_grp) begin
                        grp_cnt_next = '0;
                        out_cnt_next = out_cnt_reg + CNT_WIDTH'(1);
                        if (last_out) begin
                            state_next = DRAIN;
                        end
                    end else begin
                        grp_cnt_next = grp_cnt_reg + CNT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                mac_input_valid   = advance;
                mac_zero_operands = 1'b1;
                // Leave once this advance empties the pipe (any result left is taken now).
                if (tag_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters, config and tag pipe registers.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_reg       <= IDLE;
            grp_cnt_reg     <= '0;
            out_cnt_reg     <= '0;
            num_groups_reg  <= '0;
            num_outputs_reg <= '0;
            tag_reg         <= '0;
            consumed_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grp_cnt_reg     <= grp_cnt_next;
            out_cnt_reg     <= out_cnt_next;
            num_groups_reg  <= num_groups_next;
            num_outputs_reg <= num_outputs_next;
            tag_reg         <= tag_next;
            consumed_reg    <= consumed_next;
        end
    end

    // Output-index shadow pipe, advancing in lockstep with the MAC.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (!arst_n_in) begin
                idx_reg[i] <= '0;
            end else if (advance) begin
                idx_reg[i] <= idx_src[i];
            end
        end
    end

`ifdef MAC3_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cnt_reg;
    assign perf_stall_cycles = perf_cnt_reg;

    // Saturating count of active cycles in which the MAC did not advance.
    always_ff @(posedge clk) begin
        if (!arst_n_in || (state_reg == IDLE && start)) begin
            perf_cnt_reg <= '0;
        end else if ((state_reg == RUN || state_reg == DRAIN) && !mac_input_valid
                     && perf_cnt_reg != 32'hFFFF_FFFF) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac3_seq_ctrl.sv
// tb_mac3_seq_ctrl: directed and randomized jobs checked every cycle against a
// queue-based model of outputs in flight, plus literal timing expectations.
module tb_mac3_seq_ctrl;
    localparam int CW = 8;
    localparam int PD = 4;

    logic          clk;
    logic          arst_n_in;
    logic          start;
    logic [CW-1:0] cfg_num_groups;
    logic [CW-1:0] cfg_num_outputs;
    logic          operand_valid;
    logic          operand_ready;
    logic          mac_input_valid;
    logic          mac_accumulate;
    logic          mac_zero_operands;
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] result_index;
    logic          mac_out_written;
    logic          busy;
    logic          done;
`ifdef MAC3_SEQ_CTRL_PERF_EN
    logic [31:0]   perf_stall_cycles;
`endif

    mac3_seq_ctrl #(.CNT_WIDTH(CW), .PIPE_DEPTH(PD)) dut (
        .clk               (clk),
        .arst_n_in         (arst_n_in),
        .start             (start),
        .cfg_num_groups    (cfg_num_groups),
        .cfg_num_outputs   (cfg_num_outputs),
        .operand_valid     (operand_valid),
        .operand_ready     (operand_ready),
        .mac_input_valid   (mac_input_valid),
        .mac_accumulate    (mac_accumulate),
        .mac_zero_operands (mac_zero_operands),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_index      (result_index),
        .mac_out_written   (mac_out_written),
        .busy              (busy),
        .done              (done)
`ifdef MAC3_SEQ_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    // An output whose last group was issued is an entry travelling down the pipe;
    // it is presented to writeback at stage PD-1 until taken.
    typedef struct {
        int idx;
        int stage;
        bit cons;
    } ent_t;

    ent_t pq[$];
    ent_t nq[$];
    int   m_phase = 0;   // 0 idle, 1 issuing, 2 draining, 3 finishing
    int   m_groups = 1;
    int   m_outputs = 0;
    int   m_g = 0;
    int   m_o = 0;

    // traces of the current job (from the DUT) for literal checks
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_rel = -1;
    int   iss_q[$];
    int   acc_q[$];
    int   res_q[$];
    int   ridx_q[$];

    logic [7:0] exp_v, got_v;
    bit   e_rv, e_hold, e_issue, e_miv;
    int   e_idx, ph;

    // Compare process: predict outputs from the model, compare, then step the model.
    always @(negedge clk) begin
        ph    = m_phase;
        e_rv  = 1'b0;
        e_idx = 0;
        foreach (pq[i]) begin
            if (pq[i].stage == PD-1 && !pq[i].cons) begin
                e_rv  = 1'b1;
                e_idx = pq[i].idx;
            end
        end
        e_hold  = e_rv && !result_ready;
        e_issue = (ph == 1) && operand_valid && !e_hold;
        e_miv   = e_issue || (ph == 2 && pq.size() != 0 && !e_hold);
        exp_v = {ph != 0, ph == 3, e_issue, e_miv, (ph == 1) && (m_g != 0),
                 ph == 2, e_rv, e_rv && result_ready};
        got_v = {busy, done, operand_ready, mac_input_valid, mac_accumulate,
                 mac_zero_operands, result_valid, mac_out_written};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_outputs @%0d: got %b expected %b (busy,done,ordy,miv,acc,zero,rv,wr)",
                     cyc, got_v, exp_v);
        end
        if (e_rv) begin
            n_cmp++;
            if (int'(result_index) != e_idx) begin
                n_bad++;
                $display("FAIL result_index @%0d: got %0d expected %0d", cyc, result_index, e_idx);
            end
        end

        // job trace
        if (operand_ready === 1'b1) begin
            iss_q.push_back(cyc - start_cyc);
            acc_q.push_back(int'(mac_accumulate));
        end
        if (result_valid === 1'b1 && result_ready) begin
            res_q.push_back(cyc - start_cyc);
            ridx_q.push_back(int'(result_index));
        end
        if (done === 1'b1) done_rel = cyc - start_cyc;

        // step the model
        if (!arst_n_in) begin
            pq.delete();
            m_phase = 0;
            m_g = 0;
            m_o = 0;
        end else begin
            if (e_rv && result_ready) begin
                foreach (pq[i]) if (pq[i].stage == PD-1) pq[i].cons = 1'b1;
            end
            if (e_miv) begin
                nq = {};
                foreach (pq[i]) if (pq[i].stage < PD-1) nq.push_back('{pq[i].idx, pq[i].stage + 1, 1'b0});
                pq = nq;
            end
            case (ph)
                0: if (start) begin
                    m_groups  = (cfg_num_groups == 0) ? 1 : int'(cfg_num_groups);
                    m_outputs = int'(cfg_num_outputs);
                    m_g = 0;
                    m_o = 0;
                    m_phase = (m_outputs == 0) ? 3 : 1;
                    start_cyc = cyc;
                    done_rel = -1;
                    iss_q.delete(); acc_q.delete(); res_q.delete(); ridx_q.delete();
                end
                1: if (e_issue) begin
                    if (m_g == m_groups - 1) begin
                        pq.push_back('{m_o, 0, 1'b0});
                        m_g = 0;
                        m_o++;
                        if (m_o == m_outputs) m_phase = 2;
                    end else begin
                        m_g++;
                    end
                end
                2: if (pq.size() == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // ovm: 0 always valid, 1 toggling, 2 random. rrm: 0 always ready, 1 random
    // (plus ignored start pulses), 2 stall first result for 5 cycles.
    task automatic run_job(input int g, input int o, input int ovm, input int rrm, input int abort_after);
        int n = 0;
        int held = 0;
        cfg_num_groups  = CW'(g);
        cfg_num_outputs = CW'(o);
        start = 1'b1;
        operand_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        while (busy && n < 400) begin
            if (abort_after > 0 && n == abort_after) begin
                operand_valid = 1'b1;
                arst_n_in = 1'b0;
                tick();
                arst_n_in = 1'b1;
                break;
            end
            case (ovm)
                0:       operand_valid = 1'b1;
                1:       operand_valid = (n % 2 == 0);
                default: operand_valid = ($urandom_range(0, 9) < 7);
            endcase
            case (rrm)
                0: result_ready = 1'b1;
                1: begin
                    result_ready    = ($urandom_range(0, 9) < 6);
                    start           = ($urandom_range(0, 7) == 0);
                    cfg_num_groups  = CW'($urandom_range(0, 6));
                    cfg_num_outputs = CW'($urandom_range(0, 6));
                end
                default: begin
                    if (result_valid && held < 5) begin
                        result_ready = 1'b0;
                        held++;
                    end else begin
                        result_ready = 1'b1;
                    end
                end
            endcase
            tick();
            n++;
        end
        start = 1'b0;
        operand_valid = 1'b0;
        result_ready = 1'b1;
        if (n >= 400) chk("job_timeout", n, 0);
    endtask

    initial begin
        arst_n_in = 1'b0;
        start = 1'b0;
        operand_valid = 1'b0;
        result_ready = 1'b1;
        cfg_num_groups = '0;
        cfg_num_outputs = '0;
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_result_valid", int'(result_valid), 0);
        chk("reset_miv", int'(mac_input_valid), 0);
        arst_n_in = 1'b1;
        tick();

        // groups=3, outputs=2, no stalls
        run_job(3, 2, 0, 0, 0);
        chk("t1_issue_count", iss_q.size(), 6);
        foreach (iss_q[i]) chk("t1_issue_cycle", iss_q[i], i + 1);
        foreach (acc_q[i]) chk("t1_accumulate", acc_q[i], (i % 3 != 0) ? 1 : 0);
        chk("t1_result_count", res_q.size(), 2);
        foreach (res_q[i]) chk("t1_result_cycle", res_q[i], 7 + 3 * i);
        foreach (ridx_q[i]) chk("t1_result_index", ridx_q[i], i);
        chk("t1_done_cycle", done_rel, 11);

        // groups=1, outputs=4: back-to-back results
        run_job(1, 4, 0, 0, 0);
        foreach (acc_q[i]) chk("t2_accumulate", acc_q[i], 0);
        chk("t2_result_count", res_q.size(), 4);
        foreach (res_q[i]) chk("t2_result_cycle", res_q[i], 5 + i);
        foreach (ridx_q[i]) chk("t2_result_index", ridx_q[i], i);
        chk("t2_done_cycle", done_rel, 9);

        // first result held for 5 cycles
        run_job(2, 3, 0, 2, 0);
        chk("t3_result_count", res_q.size(), 3);
        if (res_q.size() > 0) chk("t3_first_transfer", res_q[0], 11);
        foreach (ridx_q[i]) chk("t3_result_index", ridx_q[i], i);

        // operand_valid toggling
        run_job(3, 2, 1, 0, 0);
        chk("t4_issue_count", iss_q.size(), 6);
        foreach (iss_q[i]) chk("t4_issue_cycle", iss_q[i], 1 + 2 * i);
        foreach (acc_q[i]) chk("t4_accumulate", acc_q[i], (i % 3 != 0) ? 1 : 0);
        chk("t4_result_count", res_q.size(), 2);
        foreach (ridx_q[i]) chk("t4_result_index", ridx_q[i], i);

        // zero outputs
        run_job(5, 0, 0, 0, 0);
        chk("t6_issue_count", iss_q.size(), 0);
        chk("t6_done_cycle", done_rel, 1);

        // reset in the middle of a job
        run_job(4, 5, 0, 0, 6);
        chk("t5_busy_after_reset", int'(busy), 0);
        chk("t5_ordy_after_reset", int'(operand_ready), 0);
        chk("t5_rv_after_reset", int'(result_valid), 0);
        operand_valid = 1'b0;
        repeat (3) tick();
        chk("t5_no_done", done_rel, -1);

        // randomized jobs
        for (int j = 0; j < 20; j++) begin
            int g = $urandom_range(0, 4);
            int o = $urandom_range(0, 5);
            run_job(g, o, 2, 1, 0);
            chk("rand_result_count", res_q.size(), o);
            foreach (ridx_q[i]) chk("rand_result_index", ridx_q[i], i);
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
